dmem_stall_responder: RTL and testbench

Data-memory responder on the far side of the pipelined processor's MEM-stage load/store interface. Accepts one load or store at a time, holds the pipeline with `stall` for a configurable number of cycles, then commits the write or returns load data with a one-cycle `resp_valid` pulse. It replaces the zero-wait dmem for stall-path testing and for slow memories, such as shared screen/turtle RAM.

---
 rtl/dmem_stall_responder_if.sv | 25 ++
 rtl/dmem_stall_responder.sv | 138 +++++++++++++
 tb/tb_dmem_stall_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_stall_responder_if.sv
// Load/store handshake between the MEM stage (master) and the data-memory responder (slave).
interface dmem_stall_responder_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_address;
    logic [DATA_W-1:0] req_data;
    logic              stall;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic [ADDR_W-1:0] debug_address;
    logic [DATA_W-1:0] debug_data_in;

    modport master (
        output req_valid, req_we, req_address, req_data,
        input  stall, resp_valid, resp_data, debug_address, debug_data_in
    );

    modport slave (
        input  req_valid, req_we, req_address, req_data,
        output stall, resp_valid, resp_data, debug_address, debug_data_in
    );
endinterface

// File: rtl/dmem_stall_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline LATENCY cycles per load/store.
// Optional store-tracking outputs enabled by defining DMEM_DEBUG_PORT_EN.
module dmem_stall_responder #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    dmem_stall_responder_if.slave   bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam bit SINGLE = (LATENCY == 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [DATA_W-1:0] resp_data_q;
    logic              commit_c;
    logic              cm_we;
    logic [ADDR_W-1:0] cm_addr;
    logic [DATA_W-1:0] cm_data;
    logic [IDX_W-1:0]  cm_idx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              unused_ok;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state; wait_cnt holds the stall cycles left including the current one
    always_comb begin
        state_nxt = state;
        commit_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (SINGLE) begin
                        state_nxt = S_DONE;
                        commit_c  = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.req_valid) begin
                    state_nxt = S_IDLE;
                end else if (wait_cnt <= CNT_W'(1)) begin
                    state_nxt = S_DONE;
                    commit_c  = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.stall      = bus.req_valid & (state != S_DONE);
        bus.resp_valid = (state == S_DONE);
        bus.resp_data  = resp_data_q;
    end

    // Single-cycle latency commits straight from the request, before the latch exists
    always_comb begin
        cm_we   = lat_we;
        cm_addr = lat_addr;
        cm_data = lat_data;
        if (state == S_IDLE) begin
            cm_we   = bus.req_we;
            cm_addr = bus.req_address;
            cm_data = bus.req_data;
        end
        cm_idx = cm_addr[IDX_W-1:0];
    end

    assign unused_ok = ^cm_addr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt    <= '0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_data    <= '0;
            resp_data_q <= '0;
        end else begin
            if (state == S_IDLE && bus.req_valid) begin
                lat_we   <= bus.req_we;
                lat_addr <= bus.req_address;
                lat_data <= bus.req_data;
                wait_cnt <= CNT_INIT;
            end else if (state == S_WAIT) begin
                if (!bus.req_valid)      wait_cnt <= '0;
                else if (wait_cnt != '0) wait_cnt <= wait_cnt - CNT_W'(1);
            end
            if (commit_c && !cm_we) resp_data_q <= mem[cm_idx];
        end
    end

    // Storage array is never reset; contents survive reset
    always_ff @(posedge clock) begin
        if (!reset && commit_c && cm_we) mem[cm_idx] <= cm_data;
    end

`ifdef DMEM_DEBUG_PORT_EN
    logic [ADDR_W-1:0] dbg_addr_q;
    logic [DATA_W-1:0] dbg_data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dbg_addr_q <= '0;
            dbg_data_q <= '0;
        end else if (commit_c && cm_we) begin
            dbg_addr_q <= cm_addr;
            dbg_data_q <= cm_data;
        end
    end

    assign bus.debug_address = dbg_addr_q;
    assign bus.debug_data_in = dbg_data_q;
`else
    assign bus.debug_address = '0;
    assign bus.debug_data_in = '0;
`endif

endmodule

// File: tb/tb_dmem_stall_responder.sv
// Directed bench: LATENCY=2/DEPTH=4096 instance and LATENCY=1/DEPTH=1024 instance.
module tb_dmem_stall_responder;
`ifdef DMEM_DEBUG_PORT_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    logic clock;
    logic reset;
    int   checks = 0;
    int   passes = 0;

    dmem_stall_responder_if #(.ADDR_W(12), .DATA_W(32)) bus2 ();
    dmem_stall_responder_if #(.ADDR_W(12), .DATA_W(32)) bus1 ();

    dmem_stall_responder #(.ADDR_W(12), .DATA_W(32), .DEPTH(4096), .LATENCY(2)) u_l2 (
        .clock(clock), .reset(reset), .bus(bus2)
    );
    dmem_stall_responder #(.ADDR_W(12), .DATA_W(32), .DEPTH(1024), .LATENCY(1)) u_l1 (
        .clock(clock), .reset(reset), .bus(bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input bit l1, input bit v, input bit we, input logic [11:0] a, input logic [31:0] d);
        if (l1) begin
            bus1.req_valid = v; bus1.req_we = we; bus1.req_address = a; bus1.req_data = d;
        end else begin
            bus2.req_valid = v; bus2.req_we = we; bus2.req_address = a; bus2.req_data = d;
        end
    endtask

    // One full access from a negedge; returns stall cycles, resp pulses and load data
    task automatic access(input bit l1, input bit we, input logic [11:0] a, input logic [31:0] d,
                          output int stalls, output int resps, output logic [31:0] rdata);
        drive(l1, 1'b1, we, a, d);
        stalls = 0;
        resps  = 0;
        rdata  = '0;
        for (int i = 0; i < 20 && resps == 0; i++) begin
            #1;
            if (l1 ? bus1.stall : bus2.stall) stalls++;
            if (l1 ? bus1.resp_valid : bus2.resp_valid) begin
                resps++;
                rdata = l1 ? bus1.resp_data : bus2.resp_data;
            end
            @(negedge clock);
        end
        drive(l1, 1'b0, 1'b0, 12'h0, 32'h0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0);
        @(negedge clock);
        @(negedge clock);
        #1;
        checks++; if (bus2.stall !== 1'b0) $display("FAIL rst_stall got %b want 0", bus2.stall); else passes++;
        checks++; if (bus2.resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", bus2.resp_valid); else passes++;
        checks++; if (bus2.resp_data !== 32'h0) $display("FAIL rst_resp_data got %h want 0", bus2.resp_data); else passes++;
        checks++; if (bus2.debug_address !== 12'h0) $display("FAIL rst_dbg_addr got %h want 0", bus2.debug_address); else passes++;
        bus2.req_valid = 1'b1;
        #1;
        checks++; if (bus2.stall !== 1'b1) $display("FAIL rst_stall_follows_req got %b want 1", bus2.stall); else passes++;
        bus2.req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_store_load;
        int s, r;
        logic [31:0] rd;
        access(1'b0, 1'b1, 12'd5, 32'hDEADBEEF, s, r, rd);
        checks++; if (s !== 2) $display("FAIL st_stall_cycles got %0d want 2", s); else passes++;
        checks++; if (r !== 1) $display("FAIL st_resp got %0d want 1", r); else passes++;
        checks++; if (bus2.debug_address !== (DBG ? 12'd5 : 12'd0)) $display("FAIL st_dbg_addr got %h want %h", bus2.debug_address, DBG ? 12'd5 : 12'd0); else passes++;
        checks++; if (bus2.debug_data_in !== (DBG ? 32'hDEADBEEF : 32'h0)) $display("FAIL st_dbg_data got %h want %h", bus2.debug_data_in, DBG ? 32'hDEADBEEF : 32'h0); else passes++;
        access(1'b0, 1'b0, 12'd5, 32'h0, s, r, rd);
        checks++; if (s !== 2) $display("FAIL ld_stall_cycles got %0d want 2", s); else passes++;
        checks++; if (r !== 1) $display("FAIL ld_resp got %0d want 1", r); else passes++;
        checks++; if (rd !== 32'hDEADBEEF) $display("FAIL ld_data got %h want deadbeef", rd); else passes++;
        #1;
        checks++; if (bus2.resp_valid !== 1'b0) $display("FAIL ld_single_pulse got %b want 0", bus2.resp_valid); else passes++;
        @(negedge clock);
        #1;
        checks++; if (bus2.resp_data !== 32'hDEADBEEF) $display("FAIL ld_data_hold got %h want deadbeef", bus2.resp_data); else passes++;
        @(negedge clock);
    endtask

    task automatic test_reset_async;
        #2 reset = 1'b1;
        #1;
        checks++; if (bus2.stall !== 1'b0) $display("FAIL async_stall got %b want 0", bus2.stall); else passes++;
        checks++; if (bus2.resp_valid !== 1'b0) $display("FAIL async_resp_valid got %b want 0", bus2.resp_valid); else passes++;
        checks++; if (bus2.resp_data !== 32'h0) $display("FAIL async_resp_data got %h want 0", bus2.resp_data); else passes++;
        checks++; if (bus2.debug_address !== 12'h0) $display("FAIL async_dbg_addr got %h want 0", bus2.debug_address); else passes++;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_back_to_back;
        int s, r;
        logic [31:0] rd;
        logic [31:0] vals [3];
        vals[0] = 32'h1111_0001;
        vals[1] = 32'h2222_0002;
        vals[2] = 32'h3333_0003;
        for (int i = 0; i < 3; i++) begin
            access(1'b1, 1'b1, 12'(i + 1), vals[i], s, r, rd);
            checks++; if (r !== 1) $display("FAIL b2b_store%0d resp got %0d want 1", i + 1, r); else passes++;
        end
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            access(1'b1, 1'b0, 12'(i + 1), 32'h0, s, r, rd);
            checks++; if (s !== 1) $display("FAIL b2b_load%0d stall got %0d want 1", i + 1, s); else passes++;
            checks++; if (rd !== vals[i]) $display("FAIL b2b_load%0d data got %h want %h", i + 1, rd, vals[i]); else passes++;
        end
        @(negedge clock);
    endtask

    task automatic test_abort;
        int s, r, n;
        logic [31:0] rd;
        access(1'b0, 1'b1, 12'd7, 32'h0, s, r, rd);
        checks++; if (r !== 1) $display("FAIL abort_prefill resp got %0d want 1", r); else passes++;
        drive(1'b0, 1'b1, 1'b1, 12'd7, 32'hA5A5A5A5);
        #1;
        checks++; if (bus2.stall !== 1'b1) $display("FAIL abort_stall_idle got %b want 1", bus2.stall); else passes++;
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus2.resp_valid) n++;
            @(negedge clock);
        end
        checks++; if (n !== 0) $display("FAIL abort_no_resp got %0d want 0", n); else passes++;
        access(1'b0, 1'b0, 12'd7, 32'h0, s, r, rd);
        checks++; if (s !== 2) $display("FAIL abort_reload stall got %0d want 2", s); else passes++;
        checks++; if (rd !== 32'h0) $display("FAIL abort_reload data got %h want 0", rd); else passes++;
        @(negedge clock);
    endtask

    task automatic test_wrap;
        int s, r;
        logic [31:0] rd;
        access(1'b1, 1'b1, 12'h405, 32'h12345678, s, r, rd);
        checks++; if (bus1.debug_address !== (DBG ? 12'h405 : 12'h0)) $display("FAIL wrap_dbg_addr got %h want %h", bus1.debug_address, DBG ? 12'h405 : 12'h0); else passes++;
        access(1'b1, 1'b0, 12'h005, 32'h0, s, r, rd);
        checks++; if (rd !== 32'h12345678) $display("FAIL wrap_load data got %h want 12345678", rd); else passes++;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_wait;
        int s, r;
        logic [31:0] rd;
        access(1'b0, 1'b1, 12'd9, 32'h99999999, s, r, rd);
        checks++; if (r !== 1) $display("FAIL rmw_prefill resp got %0d want 1", r); else passes++;
        drive(1'b0, 1'b1, 1'b1, 12'd9, 32'hBADC0DE5);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus2.stall !== 1'b1) $display("FAIL rmw_stall_req_held got %b want 1", bus2.stall); else passes++;
        drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        #1;
        checks++; if (bus2.stall !== 1'b0) $display("FAIL rmw_stall_drop got %b want 0", bus2.stall); else passes++;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        access(1'b0, 1'b0, 12'd9, 32'h0, s, r, rd);
        checks++; if (s !== 2) $display("FAIL rmw_reload stall got %0d want 2", s); else passes++;
        checks++; if (rd !== 32'h99999999) $display("FAIL rmw_reload data got %h want 99999999", rd); else passes++;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_reset_async();
        test_back_to_back();
        test_abort();
        test_wrap();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end
endmodule
